cam_frame_writer: RTL and testbench



---
 rtl/cam_frame_writer.sv | 120 ++++++++++++
 tb/tb_cam_frame_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: extracts luma from an OV7670 YUV422 byte stream and writes it into a
// WIDTH x HEIGHT linear grayscale frame buffer, reporting per-frame completion and integrity.
module cam_frame_writer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19,
  parameter int Y_FIRST    = 1
) (
  input  logic                  cam_PCLK,
  input  logic                  rst,
  input  logic                  cam_VSYNC,
  input  logic                  cam_HREF,
  input  logic [DATA_WIDTH-1:0] cam_D,
  input  logic                  enable,
  output logic                  pix_we,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [2:0]            err_flags,
  output logic [15:0]           frame_cnt
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [RW-1:0] H_C = RW'(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] W_A = ADDR_WIDTH'(WIDTH);
  localparam logic Y_PH = (Y_FIRST == 0);

  typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_FRAME} state_t;
  state_t state, state_n;

  logic v_q, h_q, v_p, h_p, phase;
  logic [DATA_WIDTH-1:0] d_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row, row_end;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [2:0] acc, acc_n, fin;
  logic v_rise, v_fall, h_fall, in_frame, lum, wr, line_end, start;

  assign v_rise   = v_q & ~v_p;
  assign v_fall   = ~v_q & v_p;
  assign h_fall   = ~h_q & h_p;
  assign in_frame = state == S_FRAME;
  assign lum      = in_frame && h_q && phase == Y_PH;
  assign wr       = lum && col < W_C && row < H_C;
  assign line_end = in_frame && h_fall;
  assign start    = state == S_VBLANK && v_fall && enable;
  // A line closing on the same cycle as VSYNC rising is counted before the frame checks.
  assign row_end  = (line_end && row < H_C) ? row + 1'b1 : row;
  assign fin      = {acc_n[2:1], acc_n[0] | (row_end != H_C)};

  always_comb begin
    state_n = state;
    if (state == S_SYNC && v_rise) state_n = S_VBLANK;
    else if (start) state_n = S_FRAME;
    else if (in_frame && v_rise) state_n = S_VBLANK;
  end

  always_comb begin
    acc_n = acc;
    acc_n[0] = acc[0] | (lum && row >= H_C);
    acc_n[2] = acc[2] | (lum && row < H_C && col == W_C);
    acc_n[1] = acc[1] | (line_end && row < H_C && col < W_C);
  end

  always_ff @(posedge cam_PCLK) begin
    if (rst) state <= S_SYNC;
    else state <= state_n;
  end

  always_ff @(posedge cam_PCLK) begin
    if (rst) begin
      {v_q, h_q, v_p, h_p, phase} <= '0;
      d_q        <= '0;
      col        <= '0;
      row        <= '0;
      line_base  <= '0;
      acc        <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_flags  <= '0;
      frame_cnt  <= '0;
    end else begin
      v_q        <= cam_VSYNC;
      h_q        <= cam_HREF;
      d_q        <= cam_D;
      v_p        <= v_q;
      h_p        <= h_q;
      phase      <= h_q & ~phase;
      pix_we     <= wr;
      frame_done <= in_frame && v_rise;
      if (wr) begin
        pix_addr <= line_base + ADDR_WIDTH'(col);
        pix_data <= d_q;
        col      <= col + 1'b1;
      end
      if (start) begin
        col       <= '0;
        row       <= '0;
        line_base <= '0;
        acc       <= '0;
      end else if (in_frame) begin
        acc <= acc_n;
        row <= row_end;
        if (line_end) col <= '0;
        if (line_end && row < H_C) line_base <= line_base + W_A;
      end
      if (in_frame && v_rise) begin
        err_flags <= fin;
        frame_ok  <= fin == 3'b000;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: drives YUYV/UYVY frames into two writers and checks writes and frame status.
module tb_cam_frame_writer;
  localparam int W = 8, H = 4, AW = 19, DW = 8;

  logic clk = 0, rst = 1, vs = 0, hr = 0, en = 0;
  logic [DW-1:0] d = '0;
  logic we0, dn0, ok0, we1, dn1, ok1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] q0, q1;
  logic [2:0] fl0, fl1;
  logic [15:0] cn0, cn1;

  always #5 clk = ~clk;

  cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Y_FIRST(1)) dut (
    .cam_PCLK(clk), .rst(rst), .cam_VSYNC(vs), .cam_HREF(hr), .cam_D(d), .enable(en),
    .pix_we(we0), .pix_addr(a0), .pix_data(q0), .frame_done(dn0), .frame_ok(ok0),
    .err_flags(fl0), .frame_cnt(cn0));

  cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Y_FIRST(0)) dut_u (
    .cam_PCLK(clk), .rst(rst), .cam_VSYNC(vs), .cam_HREF(hr), .cam_D(d), .enable(en),
    .pix_we(we1), .pix_addr(a1), .pix_data(q1), .frame_done(dn1), .frame_ok(ok1),
    .err_flags(fl1), .frame_cnt(cn1));

  int checks = 0, failures = 0;
  logic [26:0] wq0[$], wq1[$];
  logic [19:0] fq0[$], fq1[$];
  logic pwe[2], pdn[2];
  logic [AW-1:0] la[2];
  logic [DW-1:0] ld[2];

  bit cur_cap = 0, m_long = 0, m_short = 0;
  int m_rows = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct {
    bit en;
    int nl;
    int len[6];
    logic [2:0] ef;
  } row_t;
  row_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] q,
                     input logic dn, input logic ok, input logic [2:0] fl, input logic [15:0] cn);
    logic [26:0] e;
    logic [19:0] f;
    int sz;
    if (we) begin
      sz = (id == 0) ? wq0.size() : wq1.size();
      if (sz == 0) chk($sformatf("d%0d_spurious_we", id), 64'(we), 64'(0));
      else begin
        if (id == 0) e = wq0.pop_front();
        else e = wq1.pop_front();
        chk($sformatf("d%0d_write", id), 64'({a, q}), 64'(e));
      end
      chk($sformatf("d%0d_we_back_to_back", id), 64'(pwe[id]), 64'(0));
    end else chk($sformatf("d%0d_hold", id), 64'({a, q}), 64'({la[id], ld[id]}));
    if (dn) begin
      sz = (id == 0) ? fq0.size() : fq1.size();
      if (sz == 0) chk($sformatf("d%0d_spurious_done", id), 64'(dn), 64'(0));
      else begin
        if (id == 0) f = fq0.pop_front();
        else f = fq1.pop_front();
        chk($sformatf("d%0d_frame_status", id), 64'({ok, fl, cn}), 64'(f));
      end
      chk($sformatf("d%0d_done_width", id), 64'(pdn[id]), 64'(0));
    end
    la[id] = a;
    ld[id] = q;
    pwe[id] = we;
    pdn[id] = dn;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pwe[i] = 0;
        pdn[i] = 0;
        la[i] = '0;
        ld[i] = '0;
      end
    end else begin
      mon(0, we0, a0, q0, dn0, ok0, fl0, cn0);
      mon(1, we1, a1, q1, dn1, ok1, fl1, cn1);
    end
  end

  task automatic step(input logic v, input logic h, input logic [DW-1:0] b);
    vs = v;
    hr = h;
    d = b;
    @(posedge clk);
    #1;
  endtask

  // One line of npix pixel pairs; expected writes derived from row/column position.
  task automatic line(input int npix, input bit clean);
    logic [DW-1:0] y, c;
    int r;
    r = m_rows;
    for (int p = 0; p < npix; p++) begin
      y = clean ? 8'(8'h10 + r * W + p) : 8'($urandom);
      c = clean ? 8'hAA : 8'($urandom);
      if (cur_cap && r < H && p < W) begin
        wq0.push_back({19'(r * W + p), y});
        wq1.push_back({19'(r * W + p), c});
      end
      step(0, 1, y);
      step(0, 1, c);
    end
    if (r < H) begin
      m_long  = m_long | (npix > W);
      m_short = m_short | (npix < W);
    end
    m_rows++;
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  // Closes the current frame with a VSYNC pulse and arms the next one with en_next.
  task automatic close(input bit en_next, input bit use_exp, input logic [2:0] xf);
    logic [2:0] f;
    if (cur_cap) begin
      f = use_exp ? xf : {m_long, m_short, m_rows != H};
      exp_cnt++;
      fq0.push_back({f == 3'b000, f, exp_cnt});
      fq1.push_back({f == 3'b000, f, exp_cnt});
    end
    en = en_next;
    repeat (3) step(1, 0, 0);
    cur_cap = en_next;
    repeat (3) step(0, 0, 0);
    m_rows = 0;
    m_long = 0;
    m_short = 0;
  endtask

  task automatic setrow(input int i, input bit e, input int nl, input int l0, input int l1,
                        input int l2, input int l3, input int l4, input logic [2:0] ef);
    tbl[i].en = e;
    tbl[i].nl = nl;
    tbl[i].len = '{l0, l1, l2, l3, l4, 0};
    tbl[i].ef = ef;
  endtask

  task automatic chk_reset();
    chk("d0_reset", 64'({we0, a0, q0, dn0, ok0, fl0, cn0}), 64'(0));
    chk("d1_reset", 64'({we1, a1, q1, dn1, ok1, fl1, cn1}), 64'(0));
  endtask

  initial begin
    setrow(0, 1, 4, 8, 8, 8, 8, 0, 3'b000);
    setrow(1, 1, 4, 8, 8, 8, 8, 0, 3'b000);
    setrow(2, 1, 4, 10, 6, 8, 8, 0, 3'b110);
    setrow(3, 1, 5, 8, 8, 8, 8, 8, 3'b001);
    setrow(4, 1, 3, 8, 8, 8, 0, 0, 3'b001);
    setrow(5, 0, 4, 8, 8, 8, 8, 0, 3'b000);
    setrow(6, 1, 4, 8, 8, 8, 8, 0, 3'b000);
    setrow(7, 1, 4, 9, 8, 8, 8, 0, 3'b100);
    setrow(8, 1, 4, 8, 8, 8, 1, 0, 3'b010);

    rst = 1;
    repeat (3) step(0, 0, 0);
    chk_reset();
    rst = 0;
    close(tbl[0].en, 0, 3'b000);
    for (int i = 0; i < 9; i++) begin
      for (int r = 0; r < tbl[i].nl; r++) line(tbl[i].len[r], i < 2);
      close(i < 8 ? tbl[i + 1].en : 1'b1, 1, tbl[i].ef);
    end

    // enable drops mid-frame: current frame completes, next frame is skipped
    line(W, 0);
    line(W, 0);
    en = 0;
    line(W, 0);
    line(W, 0);
    close(0, 1, 3'b000);
    repeat (4) line(W, 0);
    close(1, 0, 3'b000);
    repeat (4) line(W, 0);
    close(1, 1, 3'b000);

    // reset while HREF is active: nothing until a full VSYNC high->low, count restarts
    line(W, 0);
    rst = 1;
    hr = 1;
    wq0.delete();
    wq1.delete();
    fq0.delete();
    fq1.delete();
    cur_cap = 0;
    exp_cnt = '0;
    m_rows = 0;
    m_long = 0;
    m_short = 0;
    step(0, 1, 8'h55);
    chk_reset();
    step(0, 1, 8'h66);
    rst = 0;
    for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom));
    step(0, 0, 0);
    step(0, 0, 0);
    line(W, 0);
    line(W, 0);
    close(1, 0, 3'b000);
    repeat (4) line(W, 0);
    close(1, 1, 3'b000);

    for (int k = 0; k < 12; k++) begin
      int nl;
      nl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 5)) : H;
      for (int r = 0; r < nl; r++)
        line(($urandom_range(0, 3) == 0) ? int'($urandom_range(W - 3, W + 3)) : W, 0);
      close($urandom_range(0, 3) != 0, 0, 3'b000);
    end

    repeat (6) step(0, 0, 0);
    chk("d0_pending_writes", 64'(wq0.size()), 64'(0));
    chk("d1_pending_writes", 64'(wq1.size()), 64'(0));
    chk("d0_pending_frames", 64'(fq0.size()), 64'(0));
    chk("d1_pending_frames", 64'(fq1.size()), 64'(0));
    chk("d0_frame_cnt", 64'(cn0), 64'(exp_cnt));
    chk("d1_frame_cnt", 64'(cn1), 64'(exp_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
